part_2_vec_capture: RTL and testbench
=====================================

# part_2_vec_capture

Upstream capture stage for a partition's initiator interface. It detects rising edges of one mission clock in the utility-clock domain and snapshots the partition's exported signals `{wen, i_data}` on each edge. Each snapshot is tagged with a wrapping sequence number and held in a small FIFO, which feeds the initiator's send state machine through a valid/ready handshake. When the FIFO nears full, the block asserts `freeze_clk_o` so the mission-clock generator stalls before any vector is lost.

## Interface

Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥ 4.
- `AF_LEVEL`, default `DEPTH-2`: occupancy at which freeze asserts; range 1..DEPTH.

Ports:
- `clk_i` in 1: utility clock. Single clock domain; all logic is on its rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `clk_mission_h` in 1: mission clock, sampled as data.
- `run_en_i` in 1: capture enable. When low, edges are ignored.
- `wen_i` in 1: exported write enable.
- `i_data_i` in 8: exported data.
- `vec_valid_o` out 1: FIFO head valid.
- `vec_data_o` out 9: head vector `{wen, data}`.
- `vec_seq_o` out 8: head sequence tag.
- `vec_ready_i` in 1: consumer accepts the head.
- `count_o` out `$clog2(DEPTH)+1`: current occupancy.
- `freeze_clk_o` out 1: stall request to the mission-clock generator.
- `ovf_o` out 1: sticky overflow flag; cleared only by reset.

## Operation

Edge detection:
- `clk_d` is a one-flop register of `clk_mission_h`. It resets to 1, so a high mission clock at reset release does not produce a spurious edge.
- `rise = clk_mission_h & ~clk_d & run_en_i`.

Push:
- On a `clk_i` edge where `rise` = 1, the block writes `{wen_i, i_data_i}` and `seq_cnt` into the tail.
- Inputs are sampled in the same cycle the edge is detected.

Sequence counter:
- `seq_cnt` is 8 bits and resets to 0.
- It increments only on an accepted push and wraps 255 → 0.

Pop:
- The FIFO is first-word-fall-through. `vec_valid_o = (count != 0)`.
- When `vec_valid_o & vec_ready_i`, the head is removed at that edge.
- `vec_data_o` and `vec_seq_o` must be held stable while valid and not popped.

Simultaneous events:
- Push and pop in the same cycle with count in 1..DEPTH: both happen; count is unchanged.
- Push when full with a pop in the same cycle: accepted.
- Push when full without a pop: dropped, `seq_cnt` is not incremented, and `ovf_o` sets to 1.
- Pop when empty: not possible, because valid is low.

Freeze:
- `freeze_clk_o` is registered: 1 when next-state count ≥ AF_LEVEL, 0 otherwise.
- There is no hysteresis.

Run enable:
- While `run_en_i` = 0, the FIFO still drains; only capture is inhibited.

Reset values (mid-operation reset included):
- Reset flushes the FIFO: count 0, pointers 0, `seq_cnt` 0.
- `vec_valid_o` 0, `vec_data_o` 0, `vec_seq_o` 0.
- `freeze_clk_o` 0, `ovf_o` 0, `clk_d` 1.

## Timing

- Mission edge to head valid: if `clk_mission_h` goes high and is first sampled 1 at `clk_i` edge N, the vector is written at edge N and `vec_valid_o` is high after edge N, so the consumer sees it in cycle N+1.
- Pop: takes effect at the edge where `valid & ready`. The next head appears after that edge, with no bubble.
- `count_o` and `freeze_clk_o` update at the same edge as the push or pop that changes occupancy.
- Mission clock constraints: each high phase and each low phase must last ≥ 1 `clk_i` period. One push occurs per high phase, regardless of high-phase length.

## Structure

- Shared package `part_2_pkg`:
  - `VEC_W = 9`.
  - `typedef struct packed {logic wen; logic [7:0] data;} part_2_vec_t`.
  - `typedef logic [7:0] part_2_seq_t`.
- Sub-module `part_2_vec_fifo`: generic synchronous FWFT FIFO with parameters `WIDTH` and `DEPTH`.
  - Signals: push, pop, full, empty, count.
  - Pointers carry an extra wrap bit.
  - It is instantiated with `WIDTH = VEC_W + 8`.
- Top level contains the edge detect, sequence counter, overflow flag and freeze compare.

## Test plan

- Basic capture: after reset, `run_en_i`=1; mission clock pulses with data A5/wen 1, then 3C/wen 0; `vec_ready_i`=1. Expect heads 0x1A5 seq 0, then 0x03C seq 1, each valid exactly one cycle, and `count_o` returns to 0.
- Backpressure and freeze, DEPTH 8 / AF_LEVEL 6: `vec_ready_i`=0; apply 6 edges. `freeze_clk_o` rises at the 6th push edge. Raise ready for one pop; freeze drops at that edge.
- Overflow: `vec_ready_i`=0; apply 9 edges. Expect `count_o`=8 and `ovf_o`=1 after the 9th edge. Drain: seq 0..7 in order, and the dropped vector never appears.
- Simultaneous push and pop while full: `vec_ready_i`=1 in the same cycle as an edge. Expect count stays 8, `ovf_o` stays 0, and the new vector lands at the tail.
- Sequence wrap and reset: stream 257 vectors with ready=1; tags run 0..255 then 0. Assert `rst_i` mid-stream with 3 entries queued: all outputs go to their reset values immediately. A mission clock held high through reset release produces no capture.

Source files
------------

// File: rtl/part_2_pkg.sv
// Shared types for the partition-2 capture path: the exported vector and its sequence tag.
package part_2_pkg;

  localparam int VEC_W = 9;
  localparam int SEQ_W = 8;

  typedef struct packed {
    logic       wen;
    logic [7:0] data;
  } part_2_vec_t;

  typedef logic [7:0] part_2_seq_t;

endpackage

// File: rtl/part_2_vec_fifo.sv
// Generic first-word-fall-through FIFO; pointers carry an extra wrap bit so full and empty
// are distinguished without a separate counter register.
module part_2_vec_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is still accepted when the head leaves at the same edge.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Masking the head while empty keeps the outputs at zero after reset without clearing storage.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/part_2_vec_capture.sv
// Captures {wen, data} on each mission-clock rising edge seen in the utility domain, tags it
// with a wrapping sequence number and queues it for the initiator, stalling the mission clock early.
module part_2_vec_capture
  import part_2_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clk_mission_h,
  input  logic                       run_en_i,
  input  logic                       wen_i,
  input  logic [7:0]                 i_data_i,
  output logic                       vec_valid_o,
  output logic [VEC_W-1:0]           vec_data_o,
  output logic [SEQ_W-1:0]           vec_seq_o,
  input  logic                       vec_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       freeze_clk_o,
  output logic                       ovf_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = VEC_W + SEQ_W;

  logic          clk_d;
  logic          rise;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  part_2_seq_t   seq_cnt;
  part_2_vec_t   vec_in;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  logic [CW-1:0] next_count;

  assign rise     = clk_mission_h & ~clk_d & run_en_i;
  assign pop      = vec_valid_o & vec_ready_i;
  assign push_ok  = rise & (~full | pop);
  assign vec_in   = '{wen: wen_i, data: i_data_i};
  assign fifo_din = {seq_cnt, vec_in};

  assign vec_valid_o = ~empty;
  assign vec_data_o  = fifo_dout[VEC_W-1:0];
  assign vec_seq_o   = fifo_dout[FW-1:VEC_W];

  assign next_count = count_o + CW'(push_ok) - CW'(pop);

  part_2_vec_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_ok),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  // clk_d resets high so a mission clock already high at reset release is not taken as an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_d        <= 1'b1;
      seq_cnt      <= '0;
      ovf_o        <= 1'b0;
      freeze_clk_o <= 1'b0;
    end else begin
      clk_d        <= clk_mission_h;
      freeze_clk_o <= (next_count >= CW'(AF_LEVEL));
      if (push_ok) seq_cnt <= seq_cnt + 1'b1;
      if (rise && !push_ok) ovf_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_part_2_vec_capture.sv
// Self-checking bench: table-driven capture rows plus scoreboarded backpressure, overflow,
// full-with-pop, sequence-wrap and mid-stream reset sequences.
module tb_part_2_vec_capture;

  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clk_mission_h;
  logic       run_en_i;
  logic       wen_i;
  logic [7:0] i_data_i;
  logic       vec_valid_o;
  logic [8:0] vec_data_o;
  logic [7:0] vec_seq_o;
  logic       vec_ready_i;
  logic [3:0] count_o;
  logic       freeze_clk_o;
  logic       ovf_o;

  part_2_vec_capture #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clk_mission_h (clk_mission_h),
    .run_en_i      (run_en_i),
    .wen_i         (wen_i),
    .i_data_i      (i_data_i),
    .vec_valid_o   (vec_valid_o),
    .vec_data_o    (vec_data_o),
    .vec_seq_o     (vec_seq_o),
    .vec_ready_i   (vec_ready_i),
    .count_o       (count_o),
    .freeze_clk_o  (freeze_clk_o),
    .ovf_o         (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [8:0] data;
    logic [7:0] seq;
  } exp_t;

  typedef struct {
    logic       mh;
    logic       run;
    logic       w;
    logic [7:0] d;
    logic       rdy;
    int         exp_count;
    logic       exp_valid;
  } row_t;

  int         total = 0;
  int         bad   = 0;
  exp_t       sb[$];
  logic [7:0] m_seq;
  logic       m_ovf;
  logic       m_clkd;
  logic [8:0] popped_data;
  logic [7:0] popped_seq;
  row_t       tbl[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One utility cycle: drive at negedge, check the head, advance the model, check after the edge.
  task automatic applyStimulus(input logic mh, input logic run, input logic w,
                               input logic [7:0] d, input logic rdy);
    logic m_pop;
    logic m_rise;
    exp_t e;
    @(negedge clk_i);
    clk_mission_h = mh;
    run_en_i      = run;
    wen_i         = w;
    i_data_i      = d;
    vec_ready_i   = rdy;
    checkOutput("valid_pre", {31'd0, vec_valid_o}, (sb.size() != 0) ? 1 : 0);
    if (sb.size() != 0) begin
      checkOutput("head_data", {23'd0, vec_data_o}, {23'd0, sb[0].data});
      checkOutput("head_seq", {24'd0, vec_seq_o}, {24'd0, sb[0].seq});
    end
    m_pop  = (sb.size() != 0) && rdy;
    m_rise = mh & ~m_clkd & run;
    m_clkd = mh;
    if (m_pop) begin
      popped_data = vec_data_o;
      popped_seq  = vec_seq_o;
      void'(sb.pop_front());
    end
    if (m_rise) begin
      if (sb.size() < DEPTH) begin
        e.data = {w, d};
        e.seq  = m_seq;
        sb.push_back(e);
        m_seq++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    checkOutput("count", {28'd0, count_o}, sb.size());
    checkOutput("freeze", {31'd0, freeze_clk_o}, (sb.size() >= AF) ? 1 : 0);
    checkOutput("ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
    checkOutput("valid", {31'd0, vec_valid_o}, (sb.size() != 0) ? 1 : 0);
  endtask

  task automatic pulse(input logic w, input logic [7:0] d, input logic rdy);
    applyStimulus(1'b1, 1'b1, w, d, rdy);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, rdy);
  endtask

  // Asserts reset at a negedge and checks the outputs clear without waiting for a clock edge.
  task automatic applyReset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    vec_ready_i = 1'b0;
    #1;
    checkOutput("rst_valid", {31'd0, vec_valid_o}, 0);
    checkOutput("rst_data", {23'd0, vec_data_o}, 0);
    checkOutput("rst_seq", {24'd0, vec_seq_o}, 0);
    checkOutput("rst_count", {28'd0, count_o}, 0);
    checkOutput("rst_freeze", {31'd0, freeze_clk_o}, 0);
    checkOutput("rst_ovf", {31'd0, ovf_o}, 0);
    sb.delete();
    m_seq = 8'd0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i  = 1'b0;
    m_clkd = clk_mission_h;
  endtask

  initial begin
    rst_i         = 1'b1;
    clk_mission_h = 1'b0;
    run_en_i      = 1'b0;
    wen_i         = 1'b0;
    i_data_i      = 8'h00;
    vec_ready_i   = 1'b0;
    m_seq         = 8'd0;
    m_ovf         = 1'b0;
    m_clkd        = 1'b1;
    popped_data   = '0;
    popped_seq    = '0;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0};

    applyReset();

    // Basic capture, run-enable gating and one push per long high phase.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].mh, tbl[i].run, tbl[i].w, tbl[i].d, tbl[i].rdy);
      checkOutput("tbl_count", {28'd0, count_o}, tbl[i].exp_count);
      checkOutput("tbl_valid", {31'd0, vec_valid_o}, {31'd0, tbl[i].exp_valid});
      if (i == 2) begin
        checkOutput("first_data", {23'd0, popped_data}, 32'h1A5);
        checkOutput("first_seq", {24'd0, popped_seq}, 0);
      end
      if (i == 4) begin
        checkOutput("second_data", {23'd0, popped_data}, 32'h03C);
        checkOutput("second_seq", {24'd0, popped_seq}, 1);
      end
      if (i == 9) checkOutput("held_high_data", {23'd0, popped_data}, 32'h011);
    end

    // Backpressure: freeze rises on the 6th push and drops on the first pop.
    applyReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 8'(i), 1'b0);
      checkOutput("freeze_edge", {31'd0, freeze_clk_o}, (i == 5) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("freeze_drop", {31'd0, freeze_clk_o}, 0);
    checkOutput("freeze_cnt", {28'd0, count_o}, 5);

    // Overflow: the 9th vector is dropped and does not consume a tag.
    applyReset();
    for (int i = 0; i < 9; i++) pulse(1'b0, 8'(8'h80 + i), 1'b0);
    checkOutput("ovf_count", {28'd0, count_o}, 8);
    checkOutput("ovf_flag", {31'd0, ovf_o}, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("drain_seq", {24'd0, popped_seq}, i);
    end
    checkOutput("drain_empty", {31'd0, vec_valid_o}, 0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC3, 1'b0);
    checkOutput("post_ovf_seq", {24'd0, vec_seq_o}, 8);
    checkOutput("post_ovf_data", {23'd0, vec_data_o}, 32'h1C3);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    // Full FIFO with push and pop at the same edge.
    applyReset();
    for (int i = 0; i < 8; i++) pulse(1'b0, 8'(8'h40 + i), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77, 1'b1);
    checkOutput("fullpp_count", {28'd0, count_o}, 8);
    checkOutput("fullpp_ovf", {31'd0, ovf_o}, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    checkOutput("fullpp_tail", {23'd0, popped_data}, 32'h177);
    checkOutput("fullpp_tseq", {24'd0, popped_seq}, 8);

    // Sequence wrap over 257 vectors.
    applyReset();
    for (int i = 0; i < 257; i++) begin
      pulse(i[0], i[7:0], 1'b1);
      if (i == 255) checkOutput("wrap_255", {24'd0, popped_seq}, 255);
    end
    checkOutput("wrap_0", {24'd0, popped_seq}, 0);
    checkOutput("wrap_cnt", {28'd0, count_o}, 0);

    // Mid-stream reset with three entries queued and mission clock held high.
    pulse(1'b0, 8'h01, 1'b0);
    pulse(1'b0, 8'h02, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A, 1'b0);
    checkOutput("pre_rst_cnt", {28'd0, count_o}, 3);
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
    checkOutput("no_capture", {28'd0, count_o}, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    checkOutput("after_rst_seq", {24'd0, vec_seq_o}, 0);
    checkOutput("after_rst_data", {23'd0, vec_data_o}, 32'h199);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
